// File: rtl/jpeg_zz_pkg.sv
// Shared definitions for the JPEG zigzag stage: coefficient width default,
// natural-to-zigzag index table and the ping-pong bank state encoding.
package jpeg_zz_pkg;

    localparam int COEF_W_DEFAULT = 8;
    localparam int BLK_N          = 64;

    // ZZ[k] is the natural (raster) index of the coefficient at zigzag position k.
    localparam int ZZ [BLK_N] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/zigzag_scan.sv
// Combinational natural-to-zigzag permutation of one 8x8 block.
// Element 0 sits in the most significant COEF_W bits on both sides.
module zigzag_scan
    import jpeg_zz_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT
) (
    input  logic [BLK_N*COEF_W-1:0] nat,
    output logic [BLK_N*COEF_W-1:0] zz
);

    for (genvar k = 0; k < BLK_N; k++) begin : g_perm
        assign zz[(BLK_N-1-k)*COEF_W +: COEF_W] = nat[(BLK_N-1-ZZ[k])*COEF_W +: COEF_W];
    end

endmodule

// File: rtl/zigzag_packer.sv
// Ping-pong row-to-block packer: collects 8 natural-order rows per bank and
// presents the full bank as one zigzag-ordered word. Define ZIGZAG_PACKER_EOB_EN to add blk_eob.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid and its data are held until that edge, and ready never depends on valid.
module zigzag_packer
    import jpeg_zz_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT,
    parameter int ROWS   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    row_valid,
    output logic                    row_ready,
    input  logic [8*COEF_W-1:0]     row_data,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [BLK_N*COEF_W-1:0] blk_data,
    output logic                    blk_first_row
`ifdef ZIGZAG_PACKER_EOB_EN
   ,output logic [6:0]              blk_eob
`endif
);

    localparam int ROW_W = 8*COEF_W;
    localparam int BLK_W = BLK_N*COEF_W;

    if (ROWS != 8) begin : g_rows_check
        $error("zigzag_packer: ROWS must be 8");
    end

    logic [BLK_W-1:0] bank_q  [2];
    bank_state_t      state_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [2:0]       wr_row_q;
    logic [BLK_W-1:0] rd_bank;
    logic             row_fire;
    logic             blk_fire;
    logic             last_row;

    assign row_ready     = (state_q[wr_ptr_q] != FULL);
    assign blk_valid     = (state_q[rd_ptr_q] == FULL);
    assign row_fire      = row_valid && row_ready;
    assign blk_fire      = blk_valid && blk_ready;
    assign last_row      = (wr_row_q == 3'(ROWS-1));
    assign blk_first_row = (wr_row_q == 3'd0);
    assign rd_bank       = bank_q[rd_ptr_q];

    zigzag_scan #(.COEF_W(COEF_W)) u_scan (
        .nat (rd_bank),
        .zz  (blk_data)
    );

    // A row write and a block read never hit the same bank: the write bank is
    // not FULL while the read bank must be FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_row_q   <= 3'd0;
        end else begin
            if (row_fire) begin
                wr_row_q <= wr_row_q + 3'd1;
                if (wr_row_q == 3'd0) begin
                    state_q[wr_ptr_q] <= FILLING;
                end
                if (last_row) begin
                    state_q[wr_ptr_q] <= FULL;
                    wr_ptr_q          <= ~wr_ptr_q;
                end
            end
            if (blk_fire) begin
                state_q[rd_ptr_q] <= EMPTY;
                rd_ptr_q          <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    if (row_fire && (wr_ptr_q == 1'(b)) && (wr_row_q == 3'(r))) begin
                        bank_q[b][(7-r)*ROW_W +: ROW_W] <= row_data;
                    end
                end
            end
        end
    end

`ifdef ZIGZAG_PACKER_EOB_EN
    logic [BLK_W-1:0] fill_nat;
    logic [BLK_W-1:0] fill_zz;
    logic [6:0]       eob_next;
    logic [6:0]       eob_q [2];

    // The bank's final contents are only complete with the incoming last row.
    assign fill_nat = {bank_q[wr_ptr_q][BLK_W-1:ROW_W], row_data};

    zigzag_scan #(.COEF_W(COEF_W)) u_eob_scan (
        .nat (fill_nat),
        .zz  (fill_zz)
    );

    always_comb begin
        eob_next = '0;
        for (int k = 0; k < BLK_N; k++) begin
            if (fill_zz[(BLK_N-1-k)*COEF_W +: COEF_W] != '0) begin
                eob_next = 7'(k+1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eob_q[0] <= '0;
            eob_q[1] <= '0;
        end else if (row_fire && last_row) begin
            eob_q[wr_ptr_q] <= eob_next;
        end
    end

    assign blk_eob = eob_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_zigzag_packer.sv
// Directed bench for zigzag_packer with a scoreboard of expected zigzag blocks.
// Define ZIGZAG_PACKER_EOB_EN to also exercise blk_eob.
module tb_zigzag_packer;

    logic         clk;
    logic         rst_n;
    logic         row_valid;
    logic         row_ready;
    logic [63:0]  row_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first_row;
`ifdef ZIGZAG_PACKER_EOB_EN
    logic [6:0]   blk_eob;
`endif

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int blk_hs = 0;
    logic [511:0] exp_q [$];
    logic [6:0]   eob_q [$];
    logic [511:0] cur_blk;
    int           tb_row = 0;

    zigzag_packer u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .row_valid     (row_valid),
        .row_ready     (row_ready),
        .row_data      (row_data),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .blk_data      (blk_data),
        .blk_first_row (blk_first_row)
`ifdef ZIGZAG_PACKER_EOB_EN
       ,.blk_eob       (blk_eob)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference zigzag built by walking the anti-diagonals of the 8x8 grid.
    function automatic logic [511:0] zz_model(input logic [511:0] nat);
        logic [511:0] z;
        int k;
        z = '0;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            for (int i = 0; i < 8; i++) begin
                int r, c;
                r = (s % 2 == 0) ? ((s < 7 ? s : 7) - i) : ((s > 7 ? s - 7 : 0) + i);
                c = s - r;
                if (r >= 0 && r <= 7 && c >= 0 && c <= 7) begin
                    z[511-8*k -: 8] = nat[511-8*(r*8+c) -: 8];
                    k++;
                end
            end
        end
        return z;
    endfunction

    function automatic logic [6:0] eob_model(input logic [511:0] z);
        logic [6:0] e;
        e = '0;
        for (int k = 0; k < 64; k++)
            if (z[511-8*k -: 8] != 8'h00) e = 7'(k+1);
        return e;
    endfunction

    function automatic logic [511:0] ramp_blk();
        logic [511:0] b;
        for (int e = 0; e < 64; e++) b[511-8*e -: 8] = 8'(e);
        return b;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int e = 0; e < 64; e++) b[511-8*e -: 8] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // driver: called at posedge+#1, returns at posedge+#1 after the accepting edge
    task automatic send_row(input logic [63:0] d);
        logic seen;
        int   waited;
        waited    = 0;
        row_valid = 1'b1;
        row_data  = d;
        forever begin
            @(negedge clk);
            seen = row_ready;
            @(posedge clk);
            #1;
            if (seen) break;
            stalls++;
            waited++;
            if (waited > 200) begin
                check("row_accept_timeout", 1'b0, 1'b1);
                row_valid = 1'b0;
                return;
            end
        end
        cur_blk[511-64*tb_row -: 64] = d;
        tb_row++;
        if (tb_row == 8) begin
            exp_q.push_back(zz_model(cur_blk));
            eob_q.push_back(eob_model(zz_model(cur_blk)));
            tb_row = 0;
        end
    endtask

    task automatic send_block(input logic [511:0] nat, input int gap_max);
        for (int r = 0; r < 8; r++) begin
            int gap;
            gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            if (gap > 0) begin
                row_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_row(nat[511-64*r -: 64]);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard: compare each handshaken block against the queue front
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready) begin
            blk_hs++;
            if (exp_q.size() == 0) begin
                check("blk_unexpected", 1'b1, 1'b0);
            end else begin
                check("blk_data", blk_data, exp_q.pop_front());
`ifdef ZIGZAG_PACKER_EOB_EN
                check("blk_eob", blk_eob, eob_q.pop_front());
`else
                void'(eob_q.pop_front());
`endif
            end
        end
    end

    initial begin
        logic [511:0] held;
        int           hs0;
        rst_n     = 1'b0;
        row_valid = 1'b0;
        row_data  = '0;
        blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_row_ready", row_ready, 1'b1);
        check("rst_blk_valid", blk_valid, 1'b0);
        check("rst_first_row", blk_first_row, 1'b1);
        check("rst_blk_data", blk_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ramp block, latency and literal byte order
        blk_ready = 1'b1;
        send_block(ramp_blk(), 0);
        row_valid = 1'b0;
        check("ramp_latency_valid", blk_valid, 1'b1);
        check("ramp_head_bytes", blk_data[511:448], 64'h000108100902030A);
        check("ramp_last_byte", blk_data[7:0], 8'h3F);
        wait_drain();

        // back-to-back: 24 rows with row_valid held high
        stalls = 0;
        hs0    = blk_hs;
        for (int b = 0; b < 3; b++) send_block(rand_blk(), 0);
        row_valid = 1'b0;
        check("b2b_no_stall", 32'(stalls), 32'd0);
        wait_drain();
        check("b2b_handshakes", 32'(blk_hs - hs0), 32'd3);

        // backpressure: fill both banks
        blk_ready = 1'b0;
        send_block(rand_blk(), 0);
        send_block(ramp_blk(), 0);
        row_valid = 1'b0;
        check("bp_row_ready_low", row_ready, 1'b0);
        check("bp_blk_valid", blk_valid, 1'b1);
        check("bp_blk1_front", blk_data, exp_q[0]);
        held      = blk_data;
        row_valid = 1'b1;
        row_data  = 64'hDEAD_BEEF_0123_4567;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_blk_stable", blk_data, held);
            check("bp_row_ready_held", row_ready, 1'b0);
        end
        check("bp_first_row", blk_first_row, 1'b1);
        row_valid = 1'b0;
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        check("bp_row_ready_back", row_ready, 1'b1);
        check("bp_blk2_valid", blk_valid, 1'b1);
        check("bp_blk2_front", blk_data, exp_q[0]);
        blk_ready = 1'b1;
        wait_drain();

        // reset mid-block
        for (int r = 0; r < 5; r++) send_row(64'hA5A5_0000_0000_0000 | 64'(r));
        row_valid = 1'b0;
        check("mid_first_row_low", blk_first_row, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_blk_valid", blk_valid, 1'b0);
        check("mid_rst_row_ready", row_ready, 1'b1);
        check("mid_rst_first_row", blk_first_row, 1'b1);
        check("mid_rst_blk_data", blk_data, '0);
        tb_row = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_block(rand_blk(), 0);
        row_valid = 1'b0;
        wait_drain();

        // input stalls of random length
        send_block(ramp_blk(), 4);
        row_valid = 1'b0;
        check("stall_latency_valid", blk_valid, 1'b1);
        check("stall_ramp_block", blk_data, zz_model(ramp_blk()));
        wait_drain();

`ifdef ZIGZAG_PACKER_EOB_EN
        begin
            logic [511:0] eb;
            eb = '0;
            eb[511:504] = 8'h05;
            eb[447:440] = 8'h03;
            send_block(eb, 0);
            row_valid = 1'b0;
            check("eob_two_nonzero", blk_eob, 7'd3);
            wait_drain();
            send_block('0, 0);
            row_valid = 1'b0;
            check("eob_all_zero", blk_eob, 7'd0);
            wait_drain();
            eb = '0;
            eb[7:0] = 8'h01;
            send_block(eb, 0);
            row_valid = 1'b0;
            check("eob_last", blk_eob, 7'd64);
            wait_drain();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
